// File: rtl/load_store_unit.sv
// Load/store unit between the EX stage and the synchronous-read data Memory.
// Optional build macro LSU_STATS_EN adds saturating load/store/error counters.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MEM_DEPTH  = 2048
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_error,
  output logic                  mem_rd,
  output logic                  mem_wn,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [1:0]            mem_mode,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]           stat_loads,
  output logic [15:0]           stat_stores,
  output logic [15:0]           stat_errors
`endif
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned EXT_W  = DATA_WIDTH - BYTE_W;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIM = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_BU   = 2'b01;
  localparam logic [1:0] MODE_BS   = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [3:0] {
    IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_MRG, RMW_WR, ERR, RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  addr0_q, addr0_d;
  logic [BYTE_W-1:0]     wbyte_q, wbyte_d;
  logic                  mem_wn_q, mem_wn_d;
  logic                  mem_rd_d, req_ready_d, resp_valid_d, resp_error_d;
  logic [ADDR_WIDTH-1:0] mem_address_d;
  logic [1:0]            mem_mode_d;
  logic [DATA_WIDTH-1:0] mem_write_data_d, resp_data_d;

  logic [ADDR_WIDTH-1:0] word_idx_c;
  logic                  req_err_c;
  logic [BYTE_W-1:0]     rd_byte_c;
  logic [DATA_WIDTH-1:0] load_fmt_c, merged_c;

  // Request decode and read-data formatting
  assign word_idx_c = ADDR_WIDTH'(req_addr[ADDR_WIDTH-1:1]);
  assign req_err_c  = (req_mode == MODE_RSVD) ||
                      ((req_mode == MODE_WORD) && req_addr[0]) ||
                      (word_idx_c >= DEPTH_LIM);
  assign rd_byte_c  = addr0_q ? mem_read_data[2*BYTE_W-1:BYTE_W] : mem_read_data[BYTE_W-1:0];
  assign merged_c   = addr0_q ? {wbyte_q, mem_read_data[BYTE_W-1:0]}
                              : {mem_read_data[2*BYTE_W-1:BYTE_W], wbyte_q};

  always_comb begin
    load_fmt_c = mem_read_data;
    case (mem_mode)
      MODE_BU: load_fmt_c = DATA_WIDTH'(rd_byte_c);
      MODE_BS: load_fmt_c = {{EXT_W{rd_byte_c[BYTE_W-1]}}, rd_byte_c};
      default: load_fmt_c = mem_read_data;
    endcase
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d          = state_q;
    addr0_d          = addr0_q;
    wbyte_d          = wbyte_q;
    mem_address_d    = mem_address;
    mem_mode_d       = mem_mode;
    mem_write_data_d = mem_write_data;
    resp_data_d      = resp_data;
    resp_error_d     = resp_error;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr0_d          = req_addr[0];
          wbyte_d          = req_wdata[BYTE_W-1:0];
          mem_address_d    = word_idx_c;
          mem_mode_d       = req_mode;
          mem_write_data_d = req_wdata;
          resp_data_d      = '0;
          resp_error_d     = 1'b0;
          if (req_err_c)                  state_d = ERR;
          else if (!req_we)               state_d = LD_RD;
          else if (req_mode == MODE_WORD) state_d = ST_WR;
          else                            state_d = RMW_RD;
        end
      end
      LD_RD:   state_d = LD_CAP;
      LD_CAP: begin
        resp_data_d = load_fmt_c;
        state_d     = RESP;
      end
      ST_WR:   state_d = RESP;
      RMW_RD:  state_d = RMW_MRG;
      RMW_MRG: begin
        mem_write_data_d = merged_c;
        state_d          = RMW_WR;
      end
      RMW_WR:  state_d = RESP;
      ERR: begin
        resp_error_d = 1'b1;
        resp_data_d  = '0;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_data_d  = '0;
          resp_error_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_rd_d     = (state_d == LD_RD) || (state_d == RMW_RD);
    mem_wn_d     = (state_d == ST_WR) || (state_d == RMW_WR);
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr0_q        <= 1'b0;
      wbyte_q        <= '0;
      mem_rd         <= 1'b0;
      mem_wn_q       <= 1'b0;
      mem_address    <= '0;
      mem_mode       <= '0;
      mem_write_data <= '0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_error     <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr0_q        <= addr0_d;
      wbyte_q        <= wbyte_d;
      mem_rd         <= mem_rd_d;
      mem_wn_q       <= mem_wn_d;
      mem_address    <= mem_address_d;
      mem_mode       <= mem_mode_d;
      mem_write_data <= mem_write_data_d;
      req_ready      <= req_ready_d;
      resp_valid     <= resp_valid_d;
      resp_data      <= resp_data_d;
      resp_error     <= resp_error_d;
    end
  end

  // Write strobe is forced low for as long as reset is asserted
  assign mem_wn = mem_wn_q & rst_n;

`ifdef LSU_STATS_EN
  logic is_store_q;

  // Saturating per-type counters, bumped on each response handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_store_q  <= 1'b0;
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errors <= '0;
    end else begin
      if (req_valid && req_ready) is_store_q <= req_we;
      if (resp_valid && resp_ready) begin
        if (resp_error) begin
          if (stat_errors != '1) stat_errors <= stat_errors + 16'd1;
        end else if (is_store_q) begin
          if (stat_stores != '1) stat_stores <= stat_stores + 16'd1;
        end else begin
          if (stat_loads != '1) stat_loads <= stat_loads + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a synchronous-read memory model and a response scoreboard.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_mode = 2'b00;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_data;
  logic        resp_error;
  logic        mem_rd, mem_wn;
  logic [15:0] mem_address;
  logic [1:0]  mem_mode;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
`ifdef LSU_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errors;
`endif

  logic [15:0] mem [0:2047];
  int rd_cnt = 0, wn_cnt = 0, both_cnt = 0;
  logic [15:0] last_wd = '0;
  int n_cmp = 0, n_mis = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_error(resp_error),
    .mem_rd(mem_rd), .mem_wn(mem_wn), .mem_address(mem_address),
    .mem_mode(mem_mode), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
`ifdef LSU_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errors(stat_errors)
`endif
  );

  always #5 clk = ~clk;

  // Memory block: 1-cycle synchronous read, synchronous write
  always @(posedge clk) begin
    if (mem_wn) begin
      mem[mem_address[10:0]] <= mem_write_data;
      wn_cnt  <= wn_cnt + 1;
      last_wd <= mem_write_data;
    end
    if (mem_rd) begin
      mem_read_data <= mem[mem_address[10:0]];
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_rd && mem_wn) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] mode, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_data,
                        input logic exp_err, input int exp_lat, input int hold,
                        input string tag);
    int   rd0, wn0, edges, exp_rd, exp_wn;
    exp_t e;
    rd0 = rd_cnt;
    wn0 = wn_cnt;
    exp_rd = (!exp_err && (!we || mode != 2'b00)) ? 1 : 0;
    exp_wn = (!exp_err && we) ? 1 : 0;
    check({tag, "/ready_before"}, 32'(req_ready), 32'd1);
    e.data = exp_data;
    e.err  = exp_err;
    sb.push_back(e);
    req_valid = 1'b1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "/ready_busy"}, 32'(req_ready), 32'd0);
    if (!exp_err) begin
      check({tag, "/mem_address"}, 32'(mem_address), 32'(addr >> 1));
      check({tag, "/mem_mode"}, 32'(mem_mode), 32'(mode));
    end
    edges = 0;
    while (resp_valid !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "/latency"}, 32'(edges + 1), 32'(exp_lat));
    e = sb.pop_front();
    check({tag, "/resp_data"}, 32'(resp_data), 32'(e.data));
    check({tag, "/resp_error"}, 32'(resp_error), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "/hold_data"}, 32'(resp_data), 32'(e.data));
      check({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, "/valid_after"}, 32'(resp_valid), 32'd0);
    check({tag, "/ready_after"}, 32'(req_ready), 32'd1);
    check({tag, "/rd_pulses"}, 32'(rd_cnt - rd0), 32'(exp_rd));
    check({tag, "/wn_pulses"}, 32'(wn_cnt - wn0), 32'(exp_wn));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wn0;
    for (int i = 0; i < 2048; i++) mem[i] <= 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/req_ready", 32'(req_ready), 32'd1);
    check("reset/resp_valid", 32'(resp_valid), 32'd0);
    check("reset/resp_data", 32'(resp_data), 32'd0);
    check("reset/resp_error", 32'(resp_error), 32'd0);
    check("reset/mem_rd", 32'(mem_rd), 32'd0);
    check("reset/mem_wn", 32'(mem_wn), 32'd0);
    check("reset/mem_address", 32'(mem_address), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then word load
    do_req(1'b1, 2'b00, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 2, 0, "s1_store");
    check("s1/last_wd", 32'(last_wd), 32'h0000BEEF);
    do_req(1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 3, 0, "s1_load");

    // Sub-word loads over 0x80FF
    mem[8] <= 16'h80FF;
    @(posedge clk); #1;
    do_req(1'b0, 2'b10, 16'h0011, 16'h0000, 16'hFF80, 1'b0, 3, 0, "s2_bs_hi");
    do_req(1'b0, 2'b01, 16'h0011, 16'h0000, 16'h0080, 1'b0, 3, 0, "s2_bu_hi");
    do_req(1'b0, 2'b10, 16'h0010, 16'h0000, 16'hFFFF, 1'b0, 3, 0, "s2_bs_lo");

    // Byte store read-modify-write
    do_req(1'b1, 2'b01, 16'h0011, 16'h0012, 16'h0000, 1'b0, 4, 0, "s3_bstore");
    check("s3/merged_wd", 32'(last_wd), 32'h000012FF);
    do_req(1'b0, 2'b00, 16'h0010, 16'h0000, 16'h12FF, 1'b0, 3, 0, "s3_load");

    // Error requests
    do_req(1'b0, 2'b00, 16'h0003, 16'h0000, 16'h0000, 1'b1, 2, 0, "s4_misalign");
    do_req(1'b0, 2'b11, 16'h0010, 16'h0000, 16'h0000, 1'b1, 2, 0, "s4_rsvd");
    do_req(1'b0, 2'b00, 16'h1000, 16'h0000, 16'h0000, 1'b1, 2, 0, "s4_range");
`ifdef LSU_STATS_EN
    check("stats/loads", 32'(stat_loads), 32'd5);
    check("stats/stores", 32'(stat_stores), 32'd2);
    check("stats/errors", 32'(stat_errors), 32'd3);
`endif

    // Back-pressure on the response
    do_req(1'b0, 2'b00, 16'h0010, 16'h0000, 16'h12FF, 1'b0, 3, 5, "s5_hold");
    do_req(1'b0, 2'b01, 16'h0010, 16'h0000, 16'h00FF, 1'b0, 3, 0, "s5_after");

    // Reset during the merge cycle of a byte store
    wn0 = wn_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_mode = 2'b01; req_addr = 16'h0011; req_wdata = 16'h0055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("s6/wn_in_reset", 32'(mem_wn), 32'd0);
    check("s6/ready_in_reset", 32'(req_ready), 32'd1);
    check("s6/valid_in_reset", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("s6/wn_pulses", 32'(wn_cnt - wn0), 32'd0);
    check("s6/mem_word", 32'(mem[8]), 32'h000012FF);
    check("s6/valid_after", 32'(resp_valid), 32'd0);
    do_req(1'b0, 2'b00, 16'h0010, 16'h0000, 16'h12FF, 1'b0, 3, 0, "s6_load");
`ifdef LSU_STATS_EN
    check("stats/after_reset_loads", 32'(stat_loads), 32'd1);
`endif

    check("end/rd_wn_overlap", 32'(both_cnt), 32'd0);
    check("end/scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
